// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: assembles big-endian 32-bit words from a UART RX strobe
// interface and writes them to instruction memory. Optional macro: INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic                  o_checksum_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
`ifdef INSTR_LOADER_CHECKSUM_EN
        S_ERR,
        S_CHK
`else
        S_ERR
`endif
    } state_t;

    state_t                  state_reg;
    logic [1:0]              byte_cnt_reg;
    logic [DATA_WIDTH-9:0]   shift_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] csum_reg;
    logic       csum_err_reg;
    assign o_checksum_err = csum_err_reg;
`else
    assign o_checksum_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            byte_cnt_reg <= 2'd0;
            shift_reg    <= '0;
            addr_reg     <= '0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_data   <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_overflow   <= 1'b0;
            o_word_count <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_reg     <= 8'd0;
            csum_err_reg <= 1'b0;
`endif
        end else begin
            // The write strobe is a single-cycle pulse; only the 4th byte in RECV raises it.
            o_mem_we <= 1'b0;
            if (i_start) begin
                state_reg    <= S_RECV;
                byte_cnt_reg <= 2'd0;
                shift_reg    <= '0;
                addr_reg     <= '0;
                o_busy       <= 1'b1;
                o_done       <= 1'b0;
                o_overflow   <= 1'b0;
                o_word_count <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum_reg     <= 8'd0;
                csum_err_reg <= 1'b0;
`endif
            end else begin
                case (state_reg)
                    S_RECV: begin
                        if (i_rx_valid) begin
                            byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                            csum_reg     <= csum_reg ^ i_rx_data;
`endif
                            if (byte_cnt_reg == 2'd3) begin
                                o_mem_we   <= 1'b1;
                                o_mem_data <= {shift_reg, i_rx_data};
                                o_mem_addr <= addr_reg;
                                state_reg  <= S_WRITE;
                            end else begin
                                shift_reg <= {shift_reg[DATA_WIDTH-17:0], i_rx_data};
                            end
                        end
                    end

                    S_WRITE: begin
                        if (o_word_count != FULL_COUNT)
                            o_word_count <= o_word_count + (ADDR_WIDTH+1)'(1);
                        if (addr_reg != LAST_ADDR)
                            addr_reg <= addr_reg + ADDR_WIDTH'(1);

                        if (o_mem_data == HALT_WORD) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                            // A byte arriving in this cycle is already the checksum byte.
                            if (i_rx_valid) begin
                                state_reg    <= S_DONE;
                                o_done       <= 1'b1;
                                o_busy       <= 1'b0;
                                csum_err_reg <= (i_rx_data != csum_reg);
                            end else begin
                                state_reg <= S_CHK;
                            end
`else
                            state_reg <= S_DONE;
                            o_done    <= 1'b1;
                            o_busy    <= 1'b0;
`endif
                        end else if (addr_reg == LAST_ADDR) begin
                            state_reg  <= S_ERR;
                            o_overflow <= 1'b1;
                            o_busy     <= 1'b0;
                        end else begin
                            state_reg <= S_RECV;
                            // Byte counter is already 0 here: this is byte 0 of the next word.
                            if (i_rx_valid) begin
                                byte_cnt_reg <= 2'd1;
                                shift_reg    <= {shift_reg[DATA_WIDTH-17:0], i_rx_data};
`ifdef INSTR_LOADER_CHECKSUM_EN
                                csum_reg     <= csum_reg ^ i_rx_data;
`endif
                            end
                        end
                    end

`ifdef INSTR_LOADER_CHECKSUM_EN
                    S_CHK: begin
                        if (i_rx_valid) begin
                            state_reg    <= S_DONE;
                            o_done       <= 1'b1;
                            o_busy       <= 1'b0;
                            csum_err_reg <= (i_rx_data != csum_reg);
                        end
                    end
`endif

                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued as words are sent
// and consumed by a write monitor. Honours INSTR_LOADER_CHECKSUM_EN when defined.
module tb_instr_mem_loader;

    localparam int AW = 6;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0;
    logic [7:0]    i_rx_data = 8'd0;
    logic          i_rx_valid = 1'b0;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_data;
    logic          o_busy;
    logic          o_done;
    logic          o_overflow;
    logic [AW:0]   o_word_count;
    logic          o_checksum_err;

    int   n_checks = 0;
    int   n_fail = 0;
    wr_t  exp_q[$];
    logic [7:0] csum_model = 8'd0;

    instr_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_rx_data(i_rx_data),
        .i_rx_valid(i_rx_valid), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_data(o_mem_data), .o_busy(o_busy), .o_done(o_done),
        .o_overflow(o_overflow), .o_word_count(o_word_count),
        .o_checksum_err(o_checksum_err)
    );

    always #5 clk = ~clk;

    // Write monitor: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (o_mem_we === 1'b1) begin
            wr_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%08h, required no write",
                         o_mem_addr, o_mem_data);
            end else begin
                e = exp_q.pop_front();
                if ({o_mem_addr, o_mem_data} !== {e.addr, e.data}) begin
                    n_fail++;
                    $display("FAIL write_data: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             o_mem_addr, o_mem_data, e.addr, e.data);
                end else begin
                    $display("write addr=%0d data=%08h", o_mem_addr, o_mem_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        csum_model = 8'd0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    // gapped=1 checks the one-cycle write latency and leaves an idle cycle after the word.
    task automatic send_word(input logic [31:0] w, input logic [AW-1:0] addr,
                             input bit expect_wr, input bit gapped);
        wr_t e;
        if (expect_wr) begin
            e.addr = addr;
            e.data = w;
            exp_q.push_back(e);
            csum_model = csum_model ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        for (int i = 0; i < 4; i++)
            send_byte(w[31-8*i -: 8]);
        if (gapped) begin
            @(negedge clk);
            n_checks++;
            if (o_mem_we !== expect_wr) begin
                n_fail++;
                $display("FAIL write_latency: o_mem_we=%b one cycle after 4th byte, required %b",
                         o_mem_we, expect_wr);
            end
            tick();
        end
    endtask

    task automatic drain();
        repeat (3) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_writes: %0d expected writes never issued, required 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_status(input string name, input logic busy, input logic done,
                                input logic ovf, input logic [AW:0] cnt);
        n_checks++;
        if ({o_busy, o_done, o_overflow, o_word_count} !== {busy, done, ovf, cnt}) begin
            n_fail++;
            $display("FAIL %s: busy/done/ovf/count=%b/%b/%b/%0d, required %b/%b/%b/%0d",
                     name, o_busy, o_done, o_overflow, o_word_count, busy, done, ovf, cnt);
        end else begin
            $display("status %s busy=%b done=%b ovf=%b count=%0d", name,
                     o_busy, o_done, o_overflow, o_word_count);
        end
    endtask

    task automatic send_checksum_if_enabled(input logic [7:0] b);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(b);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({o_mem_we, o_mem_addr, o_mem_data, o_checksum_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%b addr=%0d data=%08h cerr=%b, required all 0",
                     o_mem_we, o_mem_addr, o_mem_data, o_checksum_err);
        end
        check_status("reset", 1'b0, 1'b0, 1'b0, '0);
        rst = 1'b1;
        tick();
        // IDLE ignores bytes: no write and no session activity.
        send_word(32'h11223344, '0, 1'b0, 1'b1);
        check_status("idle_ignores_rx", 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_basic();
        start_session();
        check_status("busy_after_start", 1'b1, 1'b0, 1'b0, '0);
        send_word(32'h20080005, 6'd0, 1'b1, 1'b1);
        send_word(32'hFFFFFFFF, 6'd1, 1'b1, 1'b1);
        send_checksum_if_enabled(csum_model);
        tick();
        check_status("basic_done", 1'b0, 1'b1, 1'b0, 7'd2);
        n_checks++;
        if (o_checksum_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_cerr: o_checksum_err=%b, required 0", o_checksum_err);
        end
        drain();
    endtask

    task automatic test_done_sticky();
        send_word(32'h12345678, '0, 1'b0, 1'b1);
        check_status("done_sticky", 1'b0, 1'b1, 1'b0, 7'd2);
    endtask

    task automatic test_back_to_back();
        start_session();
        send_word(32'hA0A1A2A3, 6'd0, 1'b1, 1'b0);
        send_word(32'hB0B1B2B3, 6'd1, 1'b1, 1'b0);
        send_word(32'hC0C1C2C3, 6'd2, 1'b1, 1'b0);
        send_word(32'hFFFFFFFF, 6'd3, 1'b1, 1'b0);
        send_checksum_if_enabled(csum_model);
        drain();
        check_status("b2b_done", 1'b0, 1'b1, 1'b0, 7'd4);
    endtask

    task automatic test_overflow();
        start_session();
        for (int i = 0; i < 64; i++)
            send_word(32'h10000000 + 32'(i), AW'(i), 1'b1, 1'b0);
        drain();
        check_status("overflow", 1'b0, 1'b0, 1'b1, 7'd64);
        // ERR is sticky: no wrap back to address 0.
        send_word(32'h55667788, '0, 1'b0, 1'b1);
        check_status("overflow_sticky", 1'b0, 1'b0, 1'b1, 7'd64);
    endtask

    task automatic test_halt_at_last();
        start_session();
        for (int i = 0; i < 63; i++)
            send_word(32'h20000000 + 32'(i * 3), AW'(i), 1'b1, 1'b0);
        send_word(32'hFFFFFFFF, 6'd63, 1'b1, 1'b0);
        send_checksum_if_enabled(csum_model);
        drain();
        check_status("halt_at_last", 1'b0, 1'b1, 1'b0, 7'd64);
    endtask

    task automatic test_reset_mid();
        start_session();
        send_word(32'h01234567, 6'd0, 1'b1, 1'b1);
        send_byte(8'h9A);
        send_byte(8'hBC);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({o_mem_we, o_mem_addr, o_mem_data} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: we=%b addr=%0d data=%08h, required all 0",
                     o_mem_we, o_mem_addr, o_mem_data);
        end
        check_status("async_reset", 1'b0, 1'b0, 1'b0, '0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        start_session();
        send_word(32'hCAFEBABE, 6'd0, 1'b1, 1'b1);
        check_status("after_reset_session", 1'b1, 1'b0, 1'b0, 7'd1);
        drain();
    endtask

    task automatic test_checksum();
`ifdef INSTR_LOADER_CHECKSUM_EN
        for (int k = 0; k < 2; k++) begin
            logic [7:0] cbyte;
            cbyte = (k == 0) ? 8'h04 : 8'h05;
            start_session();
            send_word(32'h01020304, 6'd0, 1'b1, 1'b1);
            send_word(32'hFFFFFFFF, 6'd1, 1'b1, 1'b1);
            tick();
            check_status("chk_hold", 1'b1, 1'b0, 1'b0, 7'd2);
            send_byte(cbyte);
            tick();
            check_status("chk_done", 1'b0, 1'b1, 1'b0, 7'd2);
            n_checks++;
            if (o_checksum_err !== logic'(k == 1)) begin
                n_fail++;
                $display("FAIL checksum_err: byte=%02h o_checksum_err=%b, required %b",
                         cbyte, o_checksum_err, (k == 1));
            end
            drain();
        end
`else
        n_checks++;
        if (o_checksum_err !== 1'b0) begin
            n_fail++;
            $display("FAIL checksum_tied: o_checksum_err=%b, required 0", o_checksum_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_done_sticky();
        test_back_to_back();
        test_overflow();
        test_halt_at_last();
        test_reset_mid();
        test_checksum();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
